// File: rtl/matrix_stream_io_if.sv
// Element stream bundle between the host/DMA side (master) and matrix_stream_io (slave).
interface matrix_stream_io_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/matrix_stream_io.sv
// Streams n x n A and B matrices into the flat multiplier buses, waits for the
// product to settle, then streams the n x n C result back out in row-major order.
module matrix_stream_io #(
  parameter int MAX_SIZE      = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [31:0]                            size_in,
  matrix_stream_io_if.slave                      io,
  output logic [31:0]                            matrix_size,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] A,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] B,
  input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] C,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int BUS_W = MAX_SIZE * MAX_SIZE * DATA_WIDTH;
  localparam int CW    = ($clog2(MAX_SIZE) > 4) ? $clog2(MAX_SIZE) : 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           size_q, size_d;
  logic [BUS_W-1:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic [CW-1:0]         row_q, row_d, col_q, col_d, row_nx, col_nx;
  logic [7:0]            settle_q, settle_d;
  logic                  s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d, done_q, done_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  last_col, last_row, last_nx, size_ok;

  // Bit offset of element (r,c) in a flattened MAX_SIZE x MAX_SIZE bus.
  function automatic int unsigned elem_base(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return (32'(r) * 32'(MAX_SIZE) + 32'(c)) * 32'(DATA_WIDTH);
  endfunction

  // Next-state, counter and datapath update for all states.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    row_d    = row_q;
    col_d    = col_q;
    settle_d = settle_q;
    m_data_d = m_data_q;
    m_last_d = m_last_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    size_ok  = (size_in != 32'd0) && (size_in <= 32'(MAX_SIZE));
    last_col = (32'(col_q) == size_q - 32'd1);
    last_row = (32'(row_q) == size_q - 32'd1);
    if (last_col) begin
      col_nx = '0;
      row_nx = row_q + CW'(1'b1);
    end else begin
      col_nx = col_q + CW'(1'b1);
      row_nx = row_q;
    end
    last_nx = (32'(row_nx) == size_q - 32'd1) && (32'(col_nx) == size_q - 32'd1);

    case (state_q)
      IDLE: begin
        if (start && size_ok) begin
          size_d  = size_in;
          a_d     = '0;
          b_d     = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = LOAD_A;
        end else if (start) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_A, LOAD_B: begin
        if (io.s_valid && s_ready_q) begin
          if (state_q == LOAD_A) begin
            a_d[elem_base(row_q, col_q) +: DATA_WIDTH] = io.s_data;
          end else begin
            b_d[elem_base(row_q, col_q) +: DATA_WIDTH] = io.s_data;
          end
          if (last_row && last_col) begin
            row_d    = '0;
            col_d    = '0;
            settle_d = 8'(SETTLE_CYCLES);
            state_d  = (state_q == LOAD_A) ? LOAD_B : SETTLE;
          end else begin
            row_d = row_nx;
            col_d = col_nx;
          end
        end else begin
          state_d = state_q;
        end
      end
      SETTLE: begin
        if (settle_q <= 8'd1) begin
          state_d = CAPTURE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      CAPTURE: begin
        // The first element comes straight from C since c_q loads on this same edge.
        c_d      = C;
        m_data_d = C[DATA_WIDTH-1:0];
        m_last_d = (size_q == 32'd1);
        state_d  = DRAIN;
      end
      DRAIN: begin
        if (m_valid_q && io.m_ready) begin
          if (last_row && last_col) begin
            row_d    = '0;
            col_d    = '0;
            m_data_d = '0;
            m_last_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            row_d    = row_nx;
            col_d    = col_nx;
            m_data_d = c_q[elem_base(row_nx, col_nx) +: DATA_WIDTH];
            m_last_d = last_nx;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
    m_valid_d = (state_d == DRAIN);
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      size_q    <= 32'd0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      settle_q  <= 8'd0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      row_q     <= row_d;
      col_q     <= col_d;
      settle_q  <= settle_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign io.s_ready  = s_ready_q;
  assign io.m_valid  = m_valid_q;
  assign io.m_data   = m_data_q;
  assign io.m_last   = m_last_q;
  assign matrix_size = size_q;
  assign A           = a_q;
  assign B           = b_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_matrix_stream_io.sv
// Bench for matrix_stream_io: a vector table of small jobs plus randomized jobs
// checked against a plain matrix-product model; the bench also plays the multiplier.
module tb_matrix_stream_io;
  localparam int MS = 10;
  localparam int DW = 32;
  localparam int SC = 2;
  localparam int BW = MS * MS * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   size_in = 32'd0;
  logic [31:0]   matrix_size;
  logic [BW-1:0] a_bus, b_bus, c_bus;
  logic          busy, done, err;

  matrix_stream_io_if #(.DATA_WIDTH(DW)) io ();

  matrix_stream_io #(.MAX_SIZE(MS), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size_in(size_in), .io(io),
    .matrix_size(matrix_size), .A(a_bus), .B(b_bus), .C(c_bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in for the flat combinational multiplier.
  always_comb begin : mult
    logic [31:0] acc;
    c_bus = '0;
    for (int r = 0; r < MS; r++) begin
      for (int c = 0; c < MS; c++) begin
        acc = 32'd0;
        for (int k = 0; k < MS; k++) begin
          acc = acc + a_bus[(r*MS+k)*DW +: DW] * b_bus[(k*MS+c)*DW +: DW];
        end
        c_bus[(r*MS+c)*DW +: DW] = acc;
      end
    end
  end

  int cyc = 0, done_cnt = 0, err_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  int n_checks = 0, n_pass = 0, last_n = 0;
  int unsigned ma [MS][MS];
  int unsigned mb [MS][MS];
  int unsigned exp_q [$];

  typedef struct packed {
    logic [31:0]      n;
    logic [0:3][31:0] a;
    logic [0:3][31:0] b;
    logic [0:3][31:0] c;
    logic             bad;
  } vec_t;
  vec_t tbl [0:8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain n x n product, row-major, 32-bit wraparound.
  task automatic build_expect(input int n);
    int unsigned acc;
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        acc = 0;
        for (int k = 0; k < n; k++) acc += ma[r][k] * mb[k][c];
        exp_q.push_back(acc);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, io.s_ready, 1'b0);
    chk({tag, "_m_valid"}, io.m_valid, 1'b0);
    chk({tag, "_m_last"}, io.m_last, 1'b0);
    chk({tag, "_m_data"}, io.m_data, 32'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_matrix_size"}, matrix_size, 32'd0);
    chk({tag, "_AB_zero"}, (a_bus === '0) && (b_bus === '0), 1'b1);
  endtask

  // rmode: 0 = m_ready high, 1 = random, 2 = toggles every 3 cycles.
  task automatic run_job(input int n, input bit gaps, input int rmode, input bit poke,
                         input int abort_after, input bit chk_lat);
    int  k, nn, idx, guard, cyc0, d0, e0;
    bit  sr, v, mv, mr, ml, pmv, pmr, pml, first;
    logic [31:0] md, pmd;
    nn = n * n; d0 = done_cnt; e0 = err_cnt;
    start = 1'b1; size_in = n;
    tick();
    start = 1'b0; cyc0 = cyc;
    chk("accept_s_ready", io.s_ready, 1'b1);
    chk("accept_busy", busy, 1'b1);
    chk("accept_size", matrix_size, n);
    k = 0; guard = 0;
    while (k < 2*nn && guard < 20000) begin
      sr = io.s_ready;
      v  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      io.s_valid = v;
      io.s_data  = (k < nn) ? ma[k/n][k%n] : mb[(k-nn)/n][(k-nn)%n];
      start   = poke && (k >= nn) && guard[0];
      size_in = poke ? 32'd5 : n;
      tick(); guard++;
      if (sr && v) k++;
    end
    io.s_valid = 1'b0; start = 1'b0; size_in = n;
    chk("load_count", k, 2*nn);
    idx = 0; guard = 0; pmv = 1'b0; pmr = 1'b1; pmd = 32'd0; pml = 1'b0; first = 1'b1;
    while (idx < nn && guard < 20000) begin
      if (abort_after > 0 && idx == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        io.m_ready = 1'b0; start = 1'b0;
        repeat (3) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        rst_n = 1'b1; last_n = 0;
        tick();
        return;
      end
      mv = io.m_valid; md = io.m_data; ml = io.m_last;
      if (mv && first) begin
        first = 1'b0;
        if (chk_lat) chk("latency", cyc - cyc0, 2*nn + SC + 1);
      end
      if (pmv && !pmr) begin
        chk("stall_data", md, pmd);
        chk("stall_last", ml, pml);
      end
      case (rmode)
        0:       mr = 1'b1;
        1:       mr = $urandom_range(0, 1) != 0;
        default: mr = ((cyc / 3) % 2) == 0;
      endcase
      io.m_ready = mr;
      start = poke && mv && guard[0];
      if (mv && mr) begin
        chk("data", md, exp_q[idx]);
        chk("last", ml, idx == nn - 1);
        idx++;
      end
      pmv = mv; pmr = mr; pmd = md; pml = ml;
      tick(); guard++;
    end
    start = 1'b0;
    chk("drain_count", idx, nn);
    chk("done_high", done, 1'b1);
    chk("busy_low_at_done", busy, 1'b0);
    chk("m_valid_low", io.m_valid, 1'b0);
    io.m_ready = 1'b0;
    tick();
    chk("done_once", done_cnt - d0, 1);
    chk("done_pulse_end", done, 1'b0);
    if (poke) begin
      chk("poke_no_err", err_cnt - e0, 0);
      chk("poke_size_kept", matrix_size, n);
    end
    last_n = n;
  endtask

  task automatic load_vec(input int i);
    int n;
    n = tbl[i].n;
    exp_q.delete();
    for (int e = 0; e < n*n; e++) begin
      ma[e/n][e%n] = tbl[i].a[e];
      mb[e/n][e%n] = tbl[i].b[e];
      exp_q.push_back(tbl[i].c[e]);
    end
  endtask

  initial begin
    logic [BW-1:0] exp_bus;
    int e0, n;
    io.s_valid = 1'b0; io.s_data = '0; io.m_ready = 1'b0;

    tbl[0] = {32'd2,  {32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8}, {32'd19, 32'd22, 32'd43, 32'd50}, 1'b0};
    tbl[1] = {32'd2,  {32'd1, 32'd0, 32'd0, 32'd1}, {32'd9, 32'd8, 32'd7, 32'd6}, {32'd9, 32'd8, 32'd7, 32'd6}, 1'b0};
    tbl[2] = {32'd2,  {32'd2, 32'd0, 32'd0, 32'd2}, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd2, 32'd4, 32'd6, 32'd8}, 1'b0};
    tbl[3] = {32'd2,  {32'd1, 32'd1, 32'd1, 32'd1}, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd4, 32'd6, 32'd4, 32'd6}, 1'b0};
    tbl[4] = {32'd2,  {32'd0, 32'd1, 32'd1, 32'd0}, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd3, 32'd4, 32'd1, 32'd2}, 1'b0};
    tbl[5] = {32'd2,  {32'hFFFFFFFF, 32'd0, 32'd0, 32'd0}, {32'd2, 32'd0, 32'd0, 32'd0}, {32'hFFFFFFFE, 32'd0, 32'd0, 32'd0}, 1'b0};
    tbl[6] = {32'd0,  {4{32'd0}}, {4{32'd0}}, {4{32'd0}}, 1'b1};
    tbl[7] = {32'd11, {4{32'd0}}, {4{32'd0}}, {4{32'd0}}, 1'b1};
    tbl[8] = {32'd1,  {32'd7, 32'd0, 32'd0, 32'd0}, {32'd6, 32'd0, 32'd0, 32'd0}, {32'd42, 32'd0, 32'd0, 32'd0}, 1'b0};

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].bad) begin
        e0 = err_cnt;
        start = 1'b1; size_in = tbl[i].n;
        tick();
        start = 1'b0;
        chk("illegal_err", err, 1'b1);
        chk("illegal_busy", busy, 1'b0);
        chk("illegal_s_ready", io.s_ready, 1'b0);
        tick();
        chk("illegal_err_once", err_cnt - e0, 1);
        chk("illegal_err_end", err, 1'b0);
        chk("illegal_busy2", busy, 1'b0);
        chk("illegal_size_kept", matrix_size, last_n);
      end else begin
        load_vec(i);
        run_job(tbl[i].n, 1'b0, 0, 1'b0, 0, 1'b1);
      end
    end

    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(1, MS);
      for (int r = 0; r < MS; r++)
        for (int c = 0; c < MS; c++) begin
          ma[r][c] = $urandom;
          mb[r][c] = $urandom;
        end
      build_expect(n);
      run_job(n, 1'b1, 1, 1'b0, 0, 1'b0);
    end

    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r * 10 + c;
      end
    build_expect(MS);
    run_job(MS, 1'b1, 2, 1'b0, 0, 1'b0);

    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) begin
        ma[r][c] = $urandom_range(1, 1000);
        mb[r][c] = $urandom_range(1, 1000);
      end
    build_expect(3);
    run_job(3, 1'b0, 0, 1'b0, 0, 1'b1);
    load_vec(8);
    run_job(1, 1'b0, 0, 1'b0, 0, 1'b1);
    exp_bus = '0; exp_bus[31:0] = 32'd7;
    chk("pad_A", a_bus === exp_bus, 1'b1);
    exp_bus[31:0] = 32'd6;
    chk("pad_B", b_bus === exp_bus, 1'b1);

    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) begin
        ma[r][c] = $urandom_range(0, 255);
        mb[r][c] = $urandom_range(0, 255);
      end
    build_expect(4);
    run_job(4, 1'b0, 2, 1'b1, 0, 1'b0);

    load_vec(0);
    run_job(2, 1'b0, 0, 1'b0, 2, 1'b0);
    load_vec(0);
    run_job(2, 1'b0, 0, 1'b0, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
